seg7_to_digit_decoder: RTL and testbench

//   Receive side of the 7-segment digit encoding: samples a 7-bit segment bus, waits until a pattern is stable,

---
 rtl/seg7_to_digit_decoder.sv | 130 +++++++++++++
 tb/tb_seg7_to_digit_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_to_digit_decoder.sv
// Seven-segment read-back decoder: debounces seg_i, decodes stable patterns and presents them on a 1-entry valid/ready slot.
// Optional ERR_COUNT_EN adds err_cnt_o, a saturating count of invalid patterns that reached stability.
module seg7_to_digit_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [6:0] seg_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [3:0] digit_o,
  output logic       err_o,
  output logic       overrun_o
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt_o
`endif
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    REPORTED
  } state_t;

  state_t     state_q, state_d, state_eff;
  logic [6:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       report;
  logic       blank;
  logic [3:0] dec_digit;
  logic       dec_err;

  always_comb begin
    dec_digit = 4'hF;
    dec_err   = 1'b1;
    blank     = 1'b0;
    unique case (seg_i)
      7'h3F:   begin dec_digit = 4'd0; dec_err = 1'b0; end
      7'h06:   begin dec_digit = 4'd1; dec_err = 1'b0; end
      7'h5B:   begin dec_digit = 4'd2; dec_err = 1'b0; end
      7'h4F:   begin dec_digit = 4'd3; dec_err = 1'b0; end
      7'h66:   begin dec_digit = 4'd4; dec_err = 1'b0; end
      7'h6D:   begin dec_digit = 4'd5; dec_err = 1'b0; end
      7'h7D:   begin dec_digit = 4'd6; dec_err = 1'b0; end
      7'h07:   begin dec_digit = 4'd7; dec_err = 1'b0; end
      7'h7F:   begin dec_digit = 4'd8; dec_err = 1'b0; end
      7'h6F:   begin dec_digit = 4'd9; dec_err = 1'b0; end
      7'h00:   begin dec_digit = 4'd0; dec_err = 1'b0; blank = 1'b1; end
      default: begin dec_digit = 4'hF; dec_err = 1'b1; end
    endcase
  end

  // A new pattern (or any sample taken in IDLE) is judged as if already in
  // SETTLE, so STABLE_CYCLES=1 reports on the very first enabled sample.
  always_comb begin
    state_d   = state_q;
    state_eff = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    report    = 1'b0;
    if (en_i) begin
      if (seg_i != last_q) begin
        last_d    = seg_i;
        cnt_d     = 8'd1;
        state_eff = SETTLE;
      end else begin
        cnt_d     = (cnt_q >= STABLE_N) ? STABLE_N : cnt_q + 8'd1;
        state_eff = (state_q == REPORTED) ? REPORTED : SETTLE;
      end
      state_d = state_eff;
      if (state_eff == SETTLE && cnt_d == STABLE_N) begin
        if (blank) begin
          state_d = IDLE;
        end else begin
          state_d = REPORTED;
          report  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o   <= 1'b0;
      digit_o   <= '0;
      err_o     <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (report) begin
        if (!valid_o || ready_i) begin
          valid_o <= 1'b1;
          digit_o <= dec_digit;
          err_o   <= dec_err;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_o <= '0;
    end else if (report && dec_err && err_cnt_o != 8'hFF) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_to_digit_decoder.sv
// Bench for seg7_to_digit_decoder: run-length reference model compared every cycle, plus literal pins.
module tb_seg7_to_digit_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] seg = '0;
  logic       ready = 1'b0;
  logic       valid;
  logic [3:0] digit;
  logic       err;
  logic       overrun;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int acc    = 0;

  // reference model state
  logic [6:0] m_last = '0;
  int         m_run  = 0;
  logic       m_valid = 1'b0;
  logic [3:0] m_digit = '0;
  logic       m_err = 1'b0;
  logic       m_over = 1'b0;
  int         m_cnt = 0;

  seg7_to_digit_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .en_i     (en),
    .seg_i    (seg),
    .ready_i  (ready),
    .valid_o  (valid),
    .digit_o  (digit),
    .err_o    (err),
    .overrun_o(overrun)
`ifdef ERR_COUNT_EN
    ,
    .err_cnt_o(err_cnt)
`endif
  );

`ifndef ERR_COUNT_EN
  assign err_cnt = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mdecode(input logic [6:0] p, output logic [3:0] d, output logic e);
    d = 4'hF;
    e = 1'b1;
    for (int unsigned i = 0; i < 10; i++)
      if (CODES[i] == p) begin
        d = 4'(i);
        e = 1'b0;
      end
  endfunction

  // model: a report fires when the run of identical enabled samples hits STABLE exactly
  initial forever begin
    logic       rep;
    logic [3:0] d;
    logic       e;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_last = '0; m_run = 0; m_valid = 0; m_digit = '0; m_err = 0; m_over = 0; m_cnt = 0;
    end else begin
      if (valid && ready) acc++;
      rep = 1'b0;
      if (en) begin
        if (seg == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else begin m_last = seg; m_run = 1; end
        rep = (m_run == STABLE) && (seg != 7'h00);
      end
      mdecode(seg, d, e);
      m_over = 1'b0;
      if (rep) begin
        if (!m_valid || ready) begin
          m_valid = 1'b1; m_digit = d; m_err = e;
        end else m_over = 1'b1;
        if (e && m_cnt < 255) m_cnt++;
      end else if (m_valid && ready) m_valid = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_valid", 32'(valid), 32'(m_valid));
    chk("cmp_digit", 32'(digit), 32'(m_digit));
    chk("cmp_err", 32'(err), 32'(m_err));
    chk("cmp_overrun", 32'(overrun), 32'(m_over));
`ifdef ERR_COUNT_EN
    chk("cmp_err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
  end

  task automatic cyc(input logic [6:0] s, input logic e, input logic r, input int n = 1);
    for (int i = 0; i < n; i++) begin
      seg = s; en = e; ready = r;
      @(negedge clk);
    end
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_digit"}, 32'(digit), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int a0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;

    // 1: held 4F reports once, on the 4th edge
    a0 = acc;
    cyc(7'h4F, 1, 1, 3);
    chk("t1_early", 32'(valid), 0);
    cyc(7'h4F, 1, 1);
    chk("t1_valid", 32'(valid), 1);
    chk("t1_digit", 32'(digit), 3);
    chk("t1_err", 32'(err), 0);
    cyc(7'h4F, 1, 1, 6);
    chk("t1_gone", 32'(valid), 0);
    chk("t1_once", 32'(acc - a0), 1);

    // 2: short 06 glitch never reported; then en toggling
    a0 = acc;
    cyc(7'h06, 1, 1, 2);
    cyc(7'h5B, 1, 1, 4);
    chk("t2_valid", 32'(valid), 1);
    chk("t2_digit", 32'(digit), 2);
    cyc(7'h5B, 1, 1, 3);
    chk("t2_once", 32'(acc - a0), 1);
    for (int i = 0; i < 6; i++) cyc(7'h66, (i % 2) == 0, 1);
    chk("t2_en_early", 32'(valid), 0);
    cyc(7'h66, 1, 1);
    chk("t2_en_valid", 32'(valid), 1);
    chk("t2_en_digit", 32'(digit), 4);
    cyc(7'h66, 1, 1);

    // 3: invalid pattern, then saturate the error counter
    cyc(7'h49, 1, 1, 4);
    chk("t3_digit", 32'(digit), 32'hF);
    chk("t3_err", 32'(err), 1);
`ifdef ERR_COUNT_EN
    chk("t3_cnt1", 32'(err_cnt), 1);
`endif
    for (int i = 0; i < 150; i++) begin
      cyc(7'h4A, 1, 1, 4);
      cyc(7'h49, 1, 1, 4);
    end
`ifdef ERR_COUNT_EN
    chk("t3_cnt_sat", 32'(err_cnt), 32'hFF);
`endif
    cyc(7'h49, 1, 1);

    // 4: full slot drops a new result with an overrun pulse
    cyc(7'h6D, 1, 0, 4);
    chk("t4_valid", 32'(valid), 1);
    chk("t4_digit", 32'(digit), 5);
    cyc(7'h7F, 1, 0, 4);
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_keep", 32'(digit), 5);
    cyc(7'h7F, 1, 0);
    chk("t4_pulse_end", 32'(overrun), 0);
    chk("t4_still_valid", 32'(valid), 1);
    cyc(7'h7F, 1, 1);
    chk("t4_accepted", 32'(valid), 0);
    chk("t4_digit_held", 32'(digit), 5);

    // 5: blank between repeats re-arms the same digit
    a0 = acc;
    cyc(7'h06, 1, 1, 4);
    chk("t5_first", 32'(digit), 1);
    cyc(7'h00, 1, 1, 4);
    chk("t5_blank", 32'(valid), 0);
    cyc(7'h06, 1, 1, 4);
    chk("t5_second", 32'(valid), 1);
    cyc(7'h06, 1, 1, 8);
    chk("t5_two", 32'(acc - a0), 2);

    // 6: reset mid-settle and with a pending result
    cyc(7'h5B, 1, 1, 2);
    reset_now("t6a");
    cyc(7'h5B, 1, 1, 3);
    chk("t6a_early", 32'(valid), 0);
    cyc(7'h5B, 1, 1);
    chk("t6a_valid", 32'(valid), 1);
    chk("t6a_digit", 32'(digit), 2);
    cyc(7'h5B, 1, 1);
    cyc(7'h6F, 1, 0, 4);
    chk("t6b_pending", 32'(valid), 1);
    reset_now("t6b");
    cyc(7'h6F, 1, 1, 3);
    chk("t6b_early", 32'(valid), 0);
    cyc(7'h6F, 1, 1);
    chk("t6b_valid", 32'(valid), 1);
    chk("t6b_digit", 32'(digit), 9);
    cyc(7'h6F, 1, 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
